// File: rtl/inverse_gen_if.sv
// Handshake bundle for the reciprocal generator: divisor in, inverse/shift out.
interface inverse_gen_if #(
   parameter int DIVISOR_WIDTH = 5,
   parameter int WIDTH_INVERSE = 17,
   parameter int WIDTH_SHIFT   = 5
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DIVISOR_WIDTH-1:0] divisor;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH_INVERSE-1:0] div_inverse;
   logic [WIDTH_SHIFT-1:0]   div_shift;

   modport master (
      output in_valid, divisor, out_ready,
      input  in_ready, out_valid, div_inverse, div_shift
   );

   modport slave (
      input  in_valid, divisor, out_ready,
      output in_ready, out_valid, div_inverse, div_shift
   );
endinterface

// File: rtl/inverse_gen.sv
// Reciprocal generator: div_inverse = ceil(2^div_shift / d),
// div_shift = 16 + ceil(log2 d), via 17-step restoring division.
module inverse_gen #(
   parameter int DIVISOR_WIDTH = 5,
   parameter int WIDTH_INVERSE = 17,
   parameter int WIDTH_SHIFT   = 5
) (
   input logic clk,
   input logic rst,
   inverse_gen_if.slave bus
);
   localparam int RW = DIVISOR_WIDTH + 1;
   localparam int FRAC = 16;
   localparam logic [4:0] LAST = 5'd16;

   typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

   state_t state, state_nx;

   logic [RW-1:0]            dval;
   logic [RW-1:0]            rem;
   logic [RW-1:0]            rem_nx;
   logic [RW-1:0]            pow;
   logic [WIDTH_INVERSE-1:0] quo;
   logic [WIDTH_INVERSE-1:0] res_inverse;
   logic [WIDTH_SHIFT-1:0]   shift;
   logic [WIDTH_SHIFT-1:0]   res_shift;
   logic [WIDTH_SHIFT-1:0]   clog;
   logic [4:0]               cnt;
   logic                     ge;

   // Smallest k with 2^k >= d, so d <= 2^k < 2d.
   always_comb begin
      clog = '0;
      for (int k = RW - 1; k >= 0; k--) begin
         if ((RW'(1) << k) >= dval) clog = WIDTH_SHIFT'(k);
      end
      pow = RW'(1) << clog;
   end

   assign ge = rem >= dval;
   assign rem_nx = (ge ? rem - dval : rem) << 1;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.in_valid) state_nx = NORM;
         NORM:    state_nx = DIV;
         DIV:     if (cnt == LAST) state_nx = ROUND;
         ROUND:   state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dval        <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         shift       <= '0;
         res_inverse <= WIDTH_INVERSE'(1) << FRAC;
         res_shift   <= WIDTH_SHIFT'(FRAC);
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid)
                  dval <= (bus.divisor == '0) ? RW'(1) : RW'(bus.divisor);
            end
            NORM: begin
               shift <= WIDTH_SHIFT'(FRAC) + clog;
               rem   <= pow;
               quo   <= '0;
               cnt   <= '0;
            end
            DIV: begin
               quo <= {quo[WIDTH_INVERSE-2:0], ge};
               rem <= rem_nx;
               cnt <= cnt + 5'd1;
            end
            ROUND: begin
               res_inverse <= (rem != '0) ? quo + 1'b1 : quo;
               res_shift   <= shift;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.div_inverse = res_inverse;
   assign bus.div_shift   = res_shift;
endmodule

// File: tb/tb_inverse_gen.sv
// Scoreboard bench for inverse_gen: arithmetic reference model,
// cycle-level busy/latency model, directed corner cases plus random traffic.
module tb_inverse_gen;
   localparam int DW = 5;
   localparam int IW = 17;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   inverse_gen_if #(
      .DIVISOR_WIDTH(DW), .WIDTH_INVERSE(IW), .WIDTH_SHIFT(SW)
   ) bus ();

   inverse_gen #(
      .DIVISOR_WIDTH(DW), .WIDTH_INVERSE(IW), .WIDTH_SHIFT(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int inv;
      int sh;
   } res_t;

   res_t exp_q[$];
   int total = 0;
   int passed = 0;
   bit busy = 1'b0;
   int age = 0;
   int last_inv = 65536;
   int last_sh = 16;
   int got_inv = 0;
   int got_sh = 0;
   int got_n = 0;

   int kd[10] = '{0, 1, 2, 3, 5, 7, 17, 21, 27, 31};
   int ki[10] = '{65536, 65536, 65536, 87382, 104858,
                  74899, 123362, 99865, 77673, 67651};
   int ks[10] = '{16, 16, 17, 18, 19, 19, 21, 21, 21, 21};

   task automatic chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic res_t ref_calc(int d);
      res_t r;
      int dd;
      int c;
      dd = (d == 0) ? 1 : d;
      c = 0;
      while ((1 << c) < dd) c++;
      r.sh = 16 + c;
      r.inv = ((1 << r.sh) + dd - 1) / dd;
      return r;
   endfunction

   // One clock: advance the timing model on the edge, then move off it.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (busy) begin
            if (age >= 19 && bus.out_ready) busy = 1'b0;
            else age++;
         end else if (bus.in_valid) begin
            busy = 1'b1;
            age = 0;
            exp_q.push_back(ref_calc(int'(bus.divisor)));
         end
      end
      #1;
   endtask

   task automatic apply_reset(int cycles);
      rst = 1'b1;
      busy = 1'b0;
      age = 0;
      exp_q.delete();
      last_inv = 65536;
      last_sh = 16;
      bus.in_valid = 1'b0;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic send(int d);
      int n;
      bus.in_valid = 1'b1;
      bus.divisor = DW'(d);
      n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      chk("accept_timeout", int'(busy), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(bit rnd);
      int n;
      n = 0;
      while (busy && n < 400) begin
         if (rnd) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = (age < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.divisor = DW'($urandom);
         end
         tick();
         n++;
      end
      chk("done_timeout", int'(busy), 0);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!(busy && age >= 19) && n < 50) begin
         tick();
         n++;
      end
      chk("valid_timeout", int'(busy && age >= 19), 1);
   endtask

   // Monitor: compare handshake timing and data every cycle, pop on transfer.
   initial begin
      forever begin
         @(negedge clk);
         chk("in_ready", int'(bus.in_ready), int'(!busy));
         chk("out_valid", int'(bus.out_valid), int'(busy && age >= 19));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", exp_q.size(), 1);
            end else begin
               chk("div_inverse", int'(bus.div_inverse), exp_q[0].inv);
               chk("div_shift", int'(bus.div_shift), exp_q[0].sh);
               if (bus.out_ready) begin
                  got_inv = int'(bus.div_inverse);
                  got_sh = int'(bus.div_shift);
                  got_n++;
                  last_inv = exp_q[0].inv;
                  last_sh = exp_q[0].sh;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("hold_inverse", int'(bus.div_inverse), last_inv);
            chk("hold_shift", int'(bus.div_shift), last_sh);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      int n;
      bus.in_valid = 1'b0;
      bus.divisor = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      for (int d = 0; d < 32; d++) begin
         send(d);
         wait_done(1'b0);
         for (int j = 0; j < 10; j++) begin
            if (kd[j] == d) begin
               chk("table_inverse", got_inv, ki[j]);
               chk("table_shift", got_sh, ks[j]);
            end
         end
      end

      bus.out_ready = 1'b0;
      send(13);
      wait_valid();
      repeat (10) tick();
      chk("bp_inverse", int'(bus.div_inverse), 80660);
      chk("bp_shift", int'(bus.div_shift), 20);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_idle", int'(bus.in_ready), 1);
      chk("bp_pending", int'(busy), 0);

      n0 = got_n;
      send(9);
      bus.in_valid = 1'b1;
      bus.divisor = DW'(3);
      repeat (15) tick();
      bus.in_valid = 1'b0;
      wait_done(1'b0);
      repeat (5) tick();
      chk("busy_ign_inverse", got_inv, 116509);
      chk("busy_ign_shift", got_sh, 20);
      chk("busy_ign_count", got_n - n0, 1);

      send(31);
      repeat (8) tick();
      apply_reset(2);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_inverse", int'(bus.div_inverse), 65536);
      chk("rst_shift", int'(bus.div_shift), 16);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      send(31);
      wait_done(1'b0);
      chk("post_rst_inverse", got_inv, 67651);
      chk("post_rst_shift", got_sh, 21);

      bus.in_valid = 1'b1;
      bus.divisor = DW'(21);
      tick();
      chk("b2b_first_accept", int'(busy), 1);
      wait_valid();
      bus.divisor = DW'(27);
      tick();
      chk("b2b_first_inverse", got_inv, 99865);
      chk("b2b_first_shift", got_sh, 21);
      tick();
      chk("b2b_second_accept", int'(busy), 1);
      bus.in_valid = 1'b0;
      wait_done(1'b0);
      chk("b2b_second_inverse", got_inv, 77673);
      chk("b2b_second_shift", got_sh, 21);

      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 31);
         send(n);
         wait_done(1'b1);
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
